ascon_cmd_ctrl: RTL

- Synthesizable instruction sequencer that drives the key/bdi/bdo/auth interface of ascon_core from a single 32-bit host command stream.
- The host sends instruction words and their data words; the block issues the core handshakes, frames eot/eoi, holds the decrypt/hash mode, and reports tag-verification status.
- It sits between a host bus adapter (UART/AXI-stream bridge) and ascon_core.

---
 rtl/ascon_cmd_ctrl.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/ascon_cmd_ctrl.sv
// ascon_cmd_ctrl: host command sequencer for ascon_core.
// Decodes 32-bit instruction words and forwards data words to key/bdi.
module ascon_cmd_ctrl #(
    parameter int unsigned CCW  = 32,
    parameter int unsigned CCSW = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     cmd_data,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    output logic [CCW-1:0]  res_data,
    output logic [3:0]      res_type,
    output logic            res_valid,
    input  logic            res_ready,
    output logic            busy,
    output logic            auth_ok,
    output logic            auth_done,
    output logic            err,
    output logic [CCSW-1:0] key,
    output logic            key_valid,
    input  logic            key_ready,
    output logic [CCW-1:0]  bdi,
    output logic            bdi_valid,
    input  logic            bdi_ready,
    output logic [3:0]      bdi_type,
    output logic            bdi_eot,
    output logic            bdi_eoi,
    output logic            decrypt,
    output logic            hash,
    input  logic [CCW-1:0]  bdo,
    input  logic            bdo_valid,
    output logic            bdo_ready,
    input  logic [3:0]      bdo_type,
    input  logic            bdo_eot,
    input  logic            auth,
    input  logic            auth_valid,
    output logic            auth_ready
);

    localparam logic [3:0] OP_DO_ENC   = 4'h0;
    localparam logic [3:0] OP_DO_DEC   = 4'h1;
    localparam logic [3:0] OP_DO_HASH  = 4'h2;
    localparam logic [3:0] OP_LD_KEY   = 4'h3;
    localparam logic [3:0] OP_LD_NONCE = 4'h4;
    localparam logic [3:0] OP_LD_AD    = 4'h5;
    localparam logic [3:0] OP_LD_PT    = 4'h6;
    localparam logic [3:0] OP_LD_CT    = 4'h7;
    localparam logic [3:0] OP_LD_TAG   = 4'h8;

    localparam logic [3:0] D_NULL  = 4'h0;
    localparam logic [3:0] D_NONCE = 4'h1;
    localparam logic [3:0] D_AD    = 4'h2;
    localparam logic [3:0] D_PTCT  = 4'h3;
    localparam logic [3:0] D_TAG   = 4'h4;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        AUTH
    } state_t;

    state_t      state;
    logic [3:0]  op_q;
    logic        eoi_q;
    logic [22:0] cnt;

    logic [3:0]  op_in;
    logic [24:0] len_round;
    logic [22:0] words;
    logic        last;
    logic        xfer;
    logic [2:0]  unused_sig;

    assign op_in     = cmd_data[31:28];
    assign len_round = {1'b0, cmd_data[23:0]} + 25'd3;
    assign words     = len_round[24:2];
    assign last      = (cnt == 23'd1);
    assign xfer      = cmd_valid & cmd_ready;

    // The core's output side is wired straight through to the host.
    assign res_data   = bdo;
    assign res_type   = bdo_type;
    assign res_valid  = bdo_valid;
    assign bdo_ready  = res_ready;
    assign unused_sig = {bdo_eot, len_round[1:0]};

    assign busy = !rst && (state != IDLE);

    // Core-side handshake steering for the current state.
    always_comb begin
        cmd_ready  = 1'b1;
        key        = '0;
        key_valid  = 1'b0;
        bdi        = '0;
        bdi_valid  = 1'b0;
        bdi_type   = D_NULL;
        bdi_eot    = 1'b0;
        bdi_eoi    = 1'b0;
        auth_ready = 1'b0;
        if (!rst) begin
            unique case (state)
                LOAD: begin
                    if (op_q == OP_LD_KEY) begin
                        key       = cmd_data[CCSW-1:0];
                        key_valid = cmd_valid;
                        cmd_ready = key_ready;
                    end else begin
                        bdi       = cmd_data[CCW-1:0];
                        bdi_valid = cmd_valid;
                        cmd_ready = bdi_ready;
                        bdi_eot   = last;
                        bdi_eoi   = last & eoi_q;
                        unique case (op_q)
                            OP_LD_NONCE:         bdi_type = D_NONCE;
                            OP_LD_AD:            bdi_type = D_AD;
                            OP_LD_PT, OP_LD_CT:  bdi_type = D_PTCT;
                            OP_LD_TAG:           bdi_type = D_TAG;
                            default:             bdi_type = D_NULL;
                        endcase
                    end
                end
                AUTH: begin
                    cmd_ready  = 1'b0;
                    auth_ready = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // Instruction decode, word counting and auth capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            op_q      <= OP_DO_ENC;
            eoi_q     <= 1'b0;
            cnt       <= '0;
            decrypt   <= 1'b0;
            hash      <= 1'b0;
            auth_ok   <= 1'b0;
            auth_done <= 1'b0;
            err       <= 1'b0;
        end else begin
            auth_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        unique case (op_in)
                            OP_DO_ENC: begin
                                decrypt <= 1'b0;
                                hash    <= 1'b0;
                            end
                            OP_DO_DEC: begin
                                decrypt <= 1'b1;
                                hash    <= 1'b0;
                            end
                            OP_DO_HASH: begin
                                decrypt <= 1'b0;
                                hash    <= 1'b1;
                            end
                            OP_LD_KEY, OP_LD_NONCE, OP_LD_AD,
                            OP_LD_PT, OP_LD_CT, OP_LD_TAG: begin
                                op_q  <= op_in;
                                eoi_q <= cmd_data[24];
                                cnt   <= words;
                                if (words != 23'd0) begin
                                    state <= LOAD;
                                end
                            end
                            default: err <= 1'b1;
                        endcase
                    end
                end
                LOAD: begin
                    if (xfer) begin
                        cnt <= cnt - 23'd1;
                        if (last) begin
                            state <= (op_q == OP_LD_TAG) ? AUTH : IDLE;
                        end
                    end
                end
                AUTH: begin
                    if (auth_valid) begin
                        auth_ok   <= auth;
                        auth_done <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
